// File: rtl/piso_serializer_if.sv
// Parallel word handshake plus serial output bundle for the PISO serializer.
// The master drives the word side; the slave (serializer) drives everything else.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             d_ready;
  logic             s_out;
  logic             s_valid;
  logic             s_frame;
  logic             busy;
  logic             done;

  modport master (
    output d,
    output d_valid,
    input  d_ready,
    input  s_out,
    input  s_valid,
    input  s_frame,
    input  busy,
    input  done
  );

  modport slave (
    input  d,
    input  d_valid,
    output d_ready,
    output s_out,
    output s_valid,
    output s_frame,
    output busy,
    output done
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word on valid/ready, shifts it out one bit
// per clock with a first-bit frame strobe, a done pulse and a programmable inter-frame gap.
module piso_serializer #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [3:0]      GapLast = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CntW-1:0]  r_bit_cnt;
  logic [3:0]       r_gap_cnt;
  logic             r_d_ready;
  logic             r_s_out;
  logic             r_s_valid;
  logic             r_s_frame;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic [WIDTH-1:0] w_shift_rest;

  // The shift register always holds the bits still to be sent, already advanced past the
  // bit currently on s_out, so s_out can be registered straight from it.
  always_comb begin
    w_accept = bus.d_valid & r_d_ready;
    if (MSB_FIRST) begin
      w_first_bit  = bus.d[WIDTH-1];
      w_load_rest  = {bus.d[WIDTH-2:0], 1'b0};
      w_next_bit   = r_shreg[WIDTH-1];
      w_shift_rest = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin
      w_first_bit  = bus.d[0];
      w_load_rest  = {1'b0, bus.d[WIDTH-1:1]};
      w_next_bit   = r_shreg[0];
      w_shift_rest = {1'b0, r_shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_d_ready <= 1'b0;
      r_s_out   <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_frame <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_d_ready <= 1'b1;
          if (w_accept) begin
            r_shreg   <= w_load_rest;
            r_bit_cnt <= '0;
            r_s_out   <= w_first_bit;
            r_s_valid <= 1'b1;
            r_s_frame <= 1'b1;
            r_busy    <= 1'b1;
            r_d_ready <= 1'b0;
            r_state   <= StShift;
          end
        end

        StShift: begin
          r_s_frame <= 1'b0;
          if (r_bit_cnt == CntLast) begin
            r_s_out   <= 1'b0;
            r_s_valid <= 1'b0;
            r_done    <= 1'b1;
            if (GAP_CYCLES == 0) begin
              r_busy    <= 1'b0;
              r_d_ready <= 1'b1;
              r_state   <= StIdle;
            end else begin
              // The done cycle is the first gap cycle.
              r_gap_cnt <= 4'd1;
              r_state   <= StGap;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CntW'(1);
            r_s_out   <= w_next_bit;
            r_shreg   <= w_shift_rest;
          end
        end

        StGap: begin
          if (r_gap_cnt >= GapLast) begin
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
            r_d_ready <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.d_ready = r_d_ready;
  assign bus.s_out   = r_s_out;
  assign bus.s_valid = r_s_valid;
  assign bus.s_frame = r_s_frame;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (MSB/gap1, LSB/gap1, MSB/gap0) share
// one clock and reset; a frame table plus hand-written corner-case sequences.
module tb_piso_serializer;

  logic clk;
  logic rst_n;
  logic [3:0] drv_d [3];
  logic       drv_v [3];
  logic [5:0] obs   [3];

  int n_chk = 0;
  int n_err = 0;

  piso_serializer_if #(.WIDTH(4)) bus_a ();
  piso_serializer_if #(.WIDTH(4)) bus_b ();
  piso_serializer_if #(.WIDTH(4)) bus_c ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_b2b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  assign bus_a.d       = drv_d[0];
  assign bus_a.d_valid = drv_v[0];
  assign bus_b.d       = drv_d[1];
  assign bus_b.d_valid = drv_v[1];
  assign bus_c.d       = drv_d[2];
  assign bus_c.d_valid = drv_v[2];

  // Observation vector: {d_ready, s_out, s_valid, s_frame, busy, done}
  assign obs[0] = {bus_a.d_ready, bus_a.s_out, bus_a.s_valid, bus_a.s_frame, bus_a.busy,
                   bus_a.done};
  assign obs[1] = {bus_b.d_ready, bus_b.s_out, bus_b.s_valid, bus_b.s_frame, bus_b.busy,
                   bus_b.done};
  assign obs[2] = {bus_c.d_ready, bus_c.s_out, bus_c.s_valid, bus_c.s_frame, bus_c.busy,
                   bus_c.done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    logic [3:0] d;
    logic [3:0] seq;  // seq[3] is the first bit expected on s_out
    int         gap;
  } vec_t;

  function automatic logic [5:0] mk(input logic rdy, input logic out, input logic vld,
                                    input logic frm, input logic bsy, input logic dn);
    return {rdy, out, vld, frm, bsy, dn};
  endfunction

  task automatic chk(input string name, input int sel, input logic [5:0] exp);
    n_chk++;
    if (obs[sel] !== exp) begin
      n_err++;
      $display("FAIL %s (dut %0d): got rdy/out/vld/frm/bsy/dn=%b required %b at %0t",
               name, sel, obs[sel], exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [5:0] exp);
    for (int s = 0; s < 3; s++) chk(name, s, exp);
  endtask

  // Entered at a negedge with the selected DUT idle; leaves at a negedge with it idle again.
  task automatic run_frame(input int sel, input logic [3:0] d, input logic [3:0] seq,
                           input int gap);
    chk("idle_before", sel, mk(1, 0, 0, 0, 0, 0));
    drv_d[sel] = d;
    drv_v[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_v[sel] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bit%0d", i), sel, mk(0, seq[3-i], 1, (i == 0), 1, 0));
      @(negedge clk);
    end
    chk("done_cycle", sel, mk((gap == 0), 0, 0, 0, (gap != 0), 1));
    @(negedge clk);
    chk("idle_after", sel, mk(1, 0, 0, 0, 0, 0));
  endtask

  vec_t vecs [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{sel: 0, d: 4'b0011, seq: 4'b0011, gap: 1};
    vecs[1] = '{sel: 0, d: 4'b1010, seq: 4'b1010, gap: 1};
    vecs[2] = '{sel: 0, d: 4'b1000, seq: 4'b1000, gap: 1};
    vecs[3] = '{sel: 1, d: 4'b1100, seq: 4'b0011, gap: 1};
    vecs[4] = '{sel: 1, d: 4'b1010, seq: 4'b0101, gap: 1};
    vecs[5] = '{sel: 1, d: 4'b0001, seq: 4'b1000, gap: 1};
    vecs[6] = '{sel: 2, d: 4'b0110, seq: 4'b0110, gap: 0};

    // Reset held with d_valid asserted: nothing moves.
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drv_d[s] = 4'b1111;
      drv_v[s] = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      chk_all("reset_hold", mk(0, 0, 0, 0, 0, 0));
    end
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) drv_v[s] = 1'b0;
    #1;
    chk_all("release_no_edge", mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk_all("ready_after_edge", mk(1, 0, 0, 0, 0, 0));

    // Table-driven frames.
    for (int v = 0; v < 7; v++) run_frame(vecs[v].sel, vecs[v].d, vecs[v].seq, vecs[v].gap);

    // Back-to-back with gap 0: d changes after the first accept, d_valid held.
    drv_d[2] = 4'b1010;
    drv_v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_d[2] = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_f1_bit%0d", i), 2, mk(0, (i % 2 == 0), 1, (i == 0), 1, 0));
      @(negedge clk);
    end
    chk("b2b_done", 2, mk(1, 0, 0, 0, 0, 1));
    @(negedge clk);
    drv_v[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_f2_bit%0d", i), 2, mk(0, 1, 1, (i == 0), 1, 0));
      @(negedge clk);
    end
    chk("b2b_done2", 2, mk(1, 0, 0, 0, 0, 1));
    @(negedge clk);
    chk("b2b_no_third", 2, mk(1, 0, 0, 0, 0, 0));

    // d_valid pulsed mid-frame must be ignored.
    drv_d[0] = 4'b1100;
    drv_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_v[0] = 1'b0;
    chk("busy_bit0", 0, mk(0, 1, 1, 1, 1, 0));
    drv_d[0] = 4'b0101;
    drv_v[0] = 1'b1;
    @(negedge clk);
    drv_v[0] = 1'b0;
    chk("busy_bit1", 0, mk(0, 1, 1, 0, 1, 0));
    @(negedge clk);
    chk("busy_bit2", 0, mk(0, 0, 1, 0, 1, 0));
    @(negedge clk);
    chk("busy_bit3", 0, mk(0, 0, 1, 0, 1, 0));
    @(negedge clk);
    chk("busy_done", 0, mk(0, 0, 0, 0, 1, 1));
    @(negedge clk);
    chk("busy_idle", 0, mk(1, 0, 0, 0, 0, 0));
    repeat (2) begin
      @(negedge clk);
      chk("busy_no_extra", 0, mk(1, 0, 0, 0, 0, 0));
    end

    // Reset mid-frame after the second bit.
    drv_d[0] = 4'b1100;
    drv_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_v[0] = 1'b0;
    chk("rst_bit0", 0, mk(0, 1, 1, 1, 1, 0));
    @(negedge clk);
    chk("rst_bit1", 0, mk(0, 1, 1, 0, 1, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_drop", 0, mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst_no_done", 0, mk(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 4'b0011, 4'b0011, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
